// File: rtl/column_accumulator.sv
// Column accumulator bank: sums signed column partial sums per lane, snapshots the
// bank on a store command and drains it per lane or as one saturated cross-lane sum.
module column_accumulator #(
    parameter int ARR_SIZE    = 4,
    parameter int VERTICAL_BW = 32,
    parameter int ACC_BW      = 40,
    parameter int OUT_BW      = 32,
    parameter int ADDR_W      = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    input  logic [ARR_SIZE*VERTICAL_BW-1:0] in_data_i,
    input  logic                            acc_reset_i,
    input  logic                            store_output_i,
    input  logic                            reduce_mode_i,
    input  logic [ADDR_W-1:0]               op_buffer_address_i,
    output logic                            store_ready_o,
    output logic [OUT_BW-1:0]               output_data_o,
    output logic [ADDR_W-1:0]               output_buffer_addr_o,
    output logic                            output_buffer_enable_o,
    input  logic                            output_buffer_ready_i,
    output logic                            sat_flag_o
);

    localparam int IDX_W  = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
    localparam int SUM_BW = ACC_BW + $clog2(ARR_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_SIZE - 1);
    localparam logic signed [SUM_BW-1:0] SAT_MAX = {{(SUM_BW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
    localparam logic signed [SUM_BW-1:0] SAT_MIN = {{(SUM_BW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_REDUCE_SUM,
        S_REDUCE_OUT
    } state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_BW-1:0] lane_q [ARR_SIZE];
    logic signed [ACC_BW-1:0] lane_d [ARR_SIZE];
    logic signed [ACC_BW-1:0] beat_ext [ARR_SIZE];
    logic signed [ACC_BW-1:0] beat_sum [ARR_SIZE];
    logic signed [ACC_BW-1:0] snap_q [ARR_SIZE];
    logic signed [ACC_BW-1:0] snap_d [ARR_SIZE];
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [SUM_BW-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic                     sat_q, sat_d;

    logic signed [SUM_BW-1:0] snap_ext;
    logic signed [SUM_BW-1:0] emit_val;
    logic [OUT_BW-1:0]        emit_word;
    logic                     emit_clamped;

    // beat_sum is what the snapshot sees: this cycle's beat included, acc_reset ignored.
    always_comb begin
        for (int k = 0; k < ARR_SIZE; k++) begin
            beat_ext[k] = '0;
            if (in_valid_i) begin
                beat_ext[k] = ACC_BW'($signed(in_data_i[k*VERTICAL_BW +: VERTICAL_BW]));
            end
            beat_sum[k] = lane_q[k] + beat_ext[k];
            lane_d[k]   = acc_reset_i ? '0 : beat_sum[k];
        end
    end

    always_comb begin
        snap_ext     = SUM_BW'(snap_q[idx_q]);
        emit_val     = (state_q == S_REDUCE_OUT) ? sum_q : snap_ext;
        emit_word    = emit_val[OUT_BW-1:0];
        emit_clamped = 1'b0;
        if (emit_val > SAT_MAX) begin
            emit_word    = SAT_MAX[OUT_BW-1:0];
            emit_clamped = 1'b1;
        end else if (emit_val < SAT_MIN) begin
            emit_word    = SAT_MIN[OUT_BW-1:0];
            emit_clamped = 1'b1;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d                = state_q;
        idx_d                  = idx_q;
        sum_d                  = sum_q;
        snap_d                 = snap_q;
        base_d                 = base_q;
        sat_d                  = sat_q;
        store_ready_o          = 1'b0;
        output_data_o          = '0;
        output_buffer_addr_o   = '0;
        output_buffer_enable_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                store_ready_o = 1'b1;
                if (store_output_i) begin
                    snap_d  = beat_sum;
                    base_d  = op_buffer_address_i;
                    sat_d   = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = reduce_mode_i ? S_REDUCE_SUM : S_DRAIN;
                end
            end
            S_DRAIN: begin
                output_buffer_enable_o = 1'b1;
                output_data_o          = emit_word;
                output_buffer_addr_o   = base_q + ADDR_W'(idx_q);
                if (output_buffer_ready_i) begin
                    if (emit_clamped) sat_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_REDUCE_SUM: begin
                sum_d = sum_q + snap_ext;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_REDUCE_OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_REDUCE_OUT: begin
                output_buffer_enable_o = 1'b1;
                output_data_o          = emit_word;
                output_buffer_addr_o   = base_q;
                if (output_buffer_ready_i) begin
                    if (emit_clamped) sat_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sat_flag_o = sat_q;

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            base_q  <= '0;
            sat_q   <= 1'b0;
            // NOTE: lanes and snapshot are flop arrays, not RAM, so clearing them on reset is cheap.
            for (int k = 0; k < ARR_SIZE; k++) begin
                lane_q[k] <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            base_q  <= base_d;
            sat_q   <= sat_d;
            for (int k = 0; k < ARR_SIZE; k++) begin
                lane_q[k] <= lane_d[k];
                snap_q[k] <= snap_d[k];
            end
        end
    end

endmodule

// File: tb/tb_column_accumulator.sv
// Self-checking bench for column_accumulator: table vectors, directed corner sequences
// and randomized traffic, all compared against a word-queue reference model.
module tb_column_accumulator;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         acc_reset;
    logic         store_output;
    logic         reduce_mode;
    logic [3:0]   op_addr;
    logic         store_ready;
    logic [31:0]  out_data;
    logic [3:0]   out_addr;
    logic         out_en;
    logic         out_ready;
    logic         sat_flag;

    always #5 clk = ~clk;

    column_accumulator #(
        .ARR_SIZE(4), .VERTICAL_BW(32), .ACC_BW(40), .OUT_BW(32), .ADDR_W(4)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .in_valid_i             (in_valid),
        .in_data_i              (in_data),
        .acc_reset_i            (acc_reset),
        .store_output_i         (store_output),
        .reduce_mode_i          (reduce_mode),
        .op_buffer_address_i    (op_addr),
        .store_ready_o          (store_ready),
        .output_data_o          (out_data),
        .output_buffer_addr_o   (out_addr),
        .output_buffer_enable_o (out_en),
        .output_buffer_ready_i  (out_ready),
        .sat_flag_o             (sat_flag)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: lane totals as plain integers plus a queue of words still owed.
    longint      m_lane [4];
    logic [31:0] mq_data [$];
    logic [3:0]  mq_addr [$];
    bit          mq_clamp [$];
    int          m_wait;
    bit          m_sat;

    // DUT handshakes as observed on the pins.
    int          hs_cyc [$];
    logic [31:0] hs_data [$];
    logic [3:0]  hs_addr [$];

    function automatic longint wrap40(longint x);
        return (x <<< 24) >>> 24;
    endfunction

    function automatic longint lane_in(logic [127:0] d, int k);
        logic [31:0] w;
        w = d[k*32 +: 32];
        return longint'($signed(w));
    endfunction

    function automatic bit clamps(longint x);
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] sat32(longint x);
        if (x > 64'sd2147483647) return 32'h7fff_ffff;
        if (x < -64'sd2147483648) return 32'h8000_0000;
        return x[31:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_lane[k] = 0;
        mq_data.delete();
        mq_addr.delete();
        mq_clamp.delete();
        m_wait = 0;
        m_sat  = 1'b0;
    endtask

    task automatic clear_hs();
        hs_cyc.delete();
        hs_data.delete();
        hs_addr.delete();
    endtask

    // One clock cycle: drive after the edge, compare at the falling edge, advance the model.
    task automatic step(input bit v, input logic [127:0] d, input bit ar, input bit st,
                        input bit rm, input logic [3:0] b, input bit rdy, input bit r);
        bit     idle, exp_en;
        longint s [4];
        longint sum;
        @(posedge clk);
        #1;
        in_valid = v; in_data = d; acc_reset = ar; store_output = st;
        reduce_mode = rm; op_addr = b; out_ready = rdy; rst = r;
        @(negedge clk);
        cyc++;
        idle   = (mq_data.size() == 0);
        exp_en = !idle && (m_wait == 0);
        check("store_ready", 64'(store_ready), 64'(idle));
        check("enable", 64'(out_en), 64'(exp_en));
        check("sat_flag", 64'(sat_flag), 64'(m_sat));
        if (exp_en) begin
            check("data", 64'(out_data), 64'(mq_data[0]));
            check("addr", 64'(out_addr), 64'(mq_addr[0]));
        end
        if (out_en && rdy && !r) begin
            hs_cyc.push_back(cyc);
            hs_data.push_back(out_data);
            hs_addr.push_back(out_addr);
        end
        if (r) begin
            model_reset();
        end else begin
            if (exp_en && rdy) begin
                m_sat = m_sat | mq_clamp[0];
                void'(mq_data.pop_front());
                void'(mq_addr.pop_front());
                void'(mq_clamp.pop_front());
            end
            if (m_wait > 0) m_wait--;
            if (idle && st) begin
                sum = 0;
                for (int k = 0; k < 4; k++) begin
                    s[k] = wrap40(m_lane[k] + (v ? lane_in(d, k) : 0));
                    sum += s[k];
                end
                m_sat = 1'b0;
                if (rm) begin
                    mq_data.push_back(sat32(sum));
                    mq_addr.push_back(b);
                    mq_clamp.push_back(clamps(sum));
                    m_wait = 4;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        mq_data.push_back(sat32(s[k]));
                        mq_addr.push_back(b + 4'(k));
                        mq_clamp.push_back(clamps(s[k]));
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (ar) m_lane[k] = 0;
                else if (v) m_lane[k] = wrap40(m_lane[k] + lane_in(d, k));
            end
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic check_words(input string name, input int n, input logic [127:0] words,
                               input logic [3:0] base);
        logic [3:0] ea;
        check({name, "_count"}, 64'(hs_data.size()), 64'(n));
        for (int w = 0; w < n && w < hs_data.size(); w++) begin
            ea = base + 4'(w);
            check({name, "_word"}, 64'(hs_data[w]), 64'(words[w*32 +: 32]));
            check({name, "_addr"}, 64'(hs_addr[w]), 64'(ea));
        end
    endtask

    typedef struct {
        logic [127:0] data;
        int           beats;
        bit           reduce;
        logic [3:0]   base;
        logic [127:0] exp_words;
        bit           exp_sat;
    } vec_t;

    vec_t tv [6];

    function automatic logic [31:0] rand_lane();
        case ($urandom % 4)
            0:       return $urandom;
            1:       return 32'h7fff_ffff;
            2:       return 32'h8000_0000;
            default: return 32'($urandom_range(0, 15)) - 32'd8;
        endcase
    endfunction

    initial begin
        int   t;
        int   n;
        vec_t vec;

        tv[0] = '{{32'd4, 32'd3, 32'd2, 32'd1}, 3, 1'b0, 4'd2,
                  {32'd12, 32'd9, 32'd6, 32'd3}, 1'b0};
        tv[1] = '{{4{32'h7fff_ffff}}, 2, 1'b1, 4'd9,
                  {96'd0, 32'h7fff_ffff}, 1'b1};
        tv[2] = '{{32'd1, 32'd0, 32'd3, 32'hffff_fffb}, 1, 1'b1, 4'd0,
                  {96'd0, 32'hffff_ffff}, 1'b0};
        tv[3] = '{{32'd0, 32'hffff_ffff, 32'h8000_0000, 32'h7fff_ffff}, 2, 1'b0, 4'd14,
                  {32'd0, 32'hffff_fffe, 32'h8000_0000, 32'h7fff_ffff}, 1'b1};
        tv[4] = '{{4{32'h8000_0000}}, 1, 1'b1, 4'd5,
                  {96'd0, 32'h8000_0000}, 1'b1};
        tv[5] = '{{32'hffff_fff9, 32'd5, 32'hc000_0000, 32'h3fff_ffff}, 2, 1'b0, 4'd7,
                  {32'hffff_fff2, 32'd10, 32'h8000_0000, 32'h7fff_fffe}, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; acc_reset = 1'b0; store_output = 1'b0;
        reduce_mode = 1'b0; op_addr = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        check("reset_enable", 64'(out_en), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_addr", 64'(out_addr), 64'd0);
        check("reset_store_ready", 64'(store_ready), 64'd1);
        check("reset_sat", 64'(sat_flag), 64'd0);

        // Table vectors: load beats, store, drain with ready high, check words and timing.
        for (int i = 0; i < 6; i++) begin
            vec = tv[i];
            step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            for (int j = 0; j < vec.beats; j++) step(1'b1, vec.data, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            clear_hs();
            step(1'b0, '0, 1'b0, 1'b1, vec.reduce, vec.base, 1'b1, 1'b0);
            t = cyc;
            idle_steps(8);
            n = vec.reduce ? 1 : 4;
            check_words("vec", n, vec.exp_words, vec.base);
            for (int w = 0; w < n && w < hs_cyc.size(); w++)
                check("vec_latency", 64'(hs_cyc[w] - t), 64'(vec.reduce ? 5 : w + 1));
            check("vec_sat", 64'(sat_flag), 64'(vec.exp_sat));
        end

        // Backpressure: ready low for three cycles while word 1 is presented.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        repeat (3) step(1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        clear_hs();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
        t = cyc;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
            check("bp_hold_en", 64'(out_en), 64'd1);
            check("bp_hold_data", 64'(out_data), 64'd6);
            check("bp_hold_addr", 64'(out_addr), 64'd3);
        end
        idle_steps(5);
        check_words("bp", 4, {32'd12, 32'd9, 32'd6, 32'd3}, 4'd2);
        if (hs_cyc.size() == 4) check("bp_last_cycle", 64'(hs_cyc[3] - t), 64'd7);

        // Overlap: beats, acc_reset and ignored stores while draining.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        step(1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        clear_hs();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b1, {32'd40, 32'd30, 32'd20, 32'd10}, 1'b0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0);
        step(1'b1, {4{32'd1}}, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b1, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        idle_steps(4);
        check_words("ovl_drain", 4, {32'd4, 32'd3, 32'd2, 32'd1}, 4'd0);
        clear_hs();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
        idle_steps(6);
        check_words("ovl_lanes", 4, {32'd8, 32'd7, 32'd6, 32'd5}, 4'd4);

        // Beat and store in the same cycle, with the address wrapping past 15.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        clear_hs();
        step(1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 1'b1, 1'b0, 4'd14, 1'b1, 1'b0);
        idle_steps(6);
        check_words("same_cycle", 4, {32'd4, 32'd3, 32'd2, 32'd1}, 4'd14);

        // Reset while word 2 is on the bus.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        step(1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        clear_hs();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("rst_mid_en", 64'(out_en), 64'd0);
        check("rst_mid_data", 64'(out_data), 64'd0);
        check("rst_mid_addr", 64'(out_addr), 64'd0);
        check("rst_mid_store_ready", 64'(store_ready), 64'd1);
        check("rst_mid_hs_count", 64'(hs_data.size()), 64'd2);
        clear_hs();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
        idle_steps(6);
        check_words("rst_zeros", 4, 128'd0, 4'd3);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 2) == 1, {rand_lane(), rand_lane(), rand_lane(), rand_lane()},
                 ($urandom % 16) == 0, ($urandom % 6) == 0, ($urandom % 2) == 1,
                 4'($urandom), ($urandom % 4) != 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/column_accumulator.md
Name: column_accumulator

Overview:
- Per-column accumulator bank at the bottom of the systolic array. It sums ARR_SIZE signed column partial sums over successive valid beats.
- On a store command it snapshots the bank. It then drains the snapshot to the output buffer, either one word per column or as a single cross-column reduction.
- It is the successor of the fixed 4x32 accumulator. Additions: accumulator guard bits, saturation, drain handshake, and accumulation that continues while a drain is in progress.

Parameters:
- ARR_SIZE, 4, number of columns/lanes.
- VERTICAL_BW, 32, width of each signed column input.
- ACC_BW, 40, width of each signed accumulator lane; must be >= VERTICAL_BW.
- OUT_BW, 32, width of the output buffer word.
- ADDR_W, 4, output buffer address width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_data beat valid.
- in_data, input, ARR_SIZE*VERTICAL_BW, lane k is bits [k*VERTICAL_BW +: VERTICAL_BW], signed.
- acc_reset, input, 1, clear all accumulator lanes.
- store_output, input, 1, request a snapshot and drain.
- reduce_mode, input, 1, sampled with store_output: 0 = per-lane drain, 1 = single reduced word.
- op_buffer_address, input, ADDR_W, base address, sampled with store_output.
- store_ready, output, 1, high in IDLE; a store is accepted only when store_output and store_ready are both high.
- output_data, output, OUT_BW, word to the output buffer.
- output_buffer_addr, output, ADDR_W, write address.
- output_buffer_enable, output, 1, write strobe; the word is valid this cycle.
- output_buffer_ready, input, 1, the buffer accepts the word when enable and ready are both high.
- sat_flag, output, 1, sticky; set when any emitted word saturated; cleared by rst or by an accepted store.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all lanes, the snapshot, and sat_flag are cleared;
  - state=IDLE; store_ready=1;
  - output_data=0, output_buffer_addr=0, output_buffer_enable=0.
  - Reset mid-drain aborts the drain; no further enables are issued.
- Accumulate: each cycle with in_valid=1, lane[k] <= lane[k] + sign_extend(in_data_k) to ACC_BW. Lanes wrap modulo 2^ACC_BW; ACC_BW is sized so wrap does not occur in intended use.
- acc_reset=1 sets all lanes to 0 and has priority over in_valid in the same cycle. It does not affect the snapshot or an ongoing drain.
- Store accepted in cycle T:
  - the snapshot captures the lane values including cycle T's in_valid beat, and excluding any acc_reset in T. Accumulate-then-store in one cycle therefore includes the beat.
  - reduce_mode and op_buffer_address are latched;
  - sat_flag is cleared;
  - state moves to DRAIN in T+1.
  - store_output while store_ready=0 is ignored, not queued.
- Lanes keep accumulating during DRAIN; the snapshot is independent of the lanes.
- FSM states: IDLE, DRAIN, REDUCE_SUM, REDUCE_OUT.
  - IDLE: store accepted -> DRAIN if reduce_mode=0, else REDUCE_SUM.
  - DRAIN: index i runs from 0 to ARR_SIZE-1.
    - Drive output_buffer_enable=1, output_data=sat(snapshot[i]), output_buffer_addr=(base+i) mod 2^ADDR_W.
    - Hold all outputs stable while output_buffer_ready=0.
    - On handshake, i++; after handshake of i=ARR_SIZE-1 -> IDLE.
    - Enable drops the cycle after the last handshake.
  - REDUCE_SUM: serially adds the snapshot lanes into a sum register, one lane per cycle, for ARR_SIZE cycles. The sum is ACC_BW+clog2(ARR_SIZE) bits wide. -> REDUCE_OUT.
  - REDUCE_OUT: drive enable=1, data=sat(sum), addr=base; hold until ready -> IDLE.
- sat(x): if x > 2^(OUT_BW-1)-1, emit the max signed value; if x < -2^(OUT_BW-1), emit the min signed value; otherwise truncate to OUT_BW. Any clamped emission sets sat_flag in the handshake cycle.
- store_ready=1 only in IDLE.
- Latencies:
  - per-lane drain, ready held high: first enable in T+1, last in T+ARR_SIZE;
  - reduce drain: enable in T+ARR_SIZE+1.
- Address wrap: base=14, ARR_SIZE=4 (ADDR_W=4) gives addresses 14, 15, 0, 1.

Test Plan:
- Per-lane drain: rst; 3 beats with lane k=k+1 (1, 2, 3, 4); store, base=2, ready=1 -> writes 3, 6, 9, 12 at addresses 2, 3, 4, 5 in cycles T+1..T+4; sat_flag=0.
- Backpressure: as above, but ready=0 for 3 cycles at i=1 -> word 6 held at address 3 with enable high throughout; total drain is 7 cycles; no word duplicated or skipped.
- Reduce mode with saturation: lanes each 0x7FFF_FFFF x2 (0xFFFF_FFFE), reduce_mode=1, base=9 -> one write of 0x7FFF_FFFF at address 9 at T+5; sat_flag=1. Negative check: lanes -5, 3, 0, 1 -> 0xFFFF_FFFF (-1).
- Overlap: store accepted, then in_valid beats and acc_reset pulses during DRAIN -> drained words equal the snapshot; the lanes reflect only the post-store activity; store_output during DRAIN is ignored (exactly ARR_SIZE enables).
- Same-cycle events: in_valid with acc_reset -> lanes=0. in_valid with store -> the snapshot includes the beat. Base=14 -> addresses wrap to 14, 15, 0, 1.
- Reset mid-drain: rst at i=2 -> next cycle enable=0, data=0, addr=0, store_ready=1; a subsequent store drains zeros.
